data_sram_responder: RTL and testbench
======================================

// Module: data_sram_responder
// PURPOSE
//   Responder side of the data_sram request interface driven by the memory stage.
//   Accepts one request per cycle (en/we/addr/wdata) and applies byte-enabled writes.
//   Returns read data after a fixed, parameterised latency, with a valid strobe and an
//   out-of-range error flag. Serves as the data memory behind the CPU top in simulation
//   and FPGA builds.
// PARAMETERS
//   DEPTH   1024  number of 32-bit words; must be a power of 2; ADDR_W = log2(DEPTH)
//   RD_LAT  1     read latency in cycles from accepting edge to rdata_valid; legal 1..4
//   BASE    32'h0 byte base address of the array; window is [BASE, BASE+4*DEPTH)
// PORTS
//   clk              in   1   clock; all state updates on the rising edge
//   resetn           in   1   asynchronous reset, active-low
//   data_sram_en     in   1   request strobe; a request is accepted on every edge with en=1
//   data_sram_we     in   4   byte write enables; lane i writes wdata[8i+7:8i]; 4'b0000 = read
//   data_sram_addr   in   32  byte address; bits [1:0] ignored (word aligned)
//   data_sram_wdata  in   32  write data
//   data_sram_rdata  out  32  read data; holds its last value between reads
//   rdata_valid      out  1   1-cycle pulse when data_sram_rdata carries a new read result
//   addr_err         out  1   1-cycle pulse: the request completing now was out of window
//   rd_count         out  32  number of accepted reads; wraps at 2^32
//   wr_count         out  32  number of accepted writes (we!=0); wraps at 2^32
// BEHAVIOUR
//   Reset (resetn=0, async): data_sram_rdata=0, rdata_valid=0, addr_err=0, rd_count=0,
//     wr_count=0, read pipeline emptied. Array contents are NOT reset.
//   Decode: off = addr - BASE (32-bit, wraps); in_win = (off < 4*DEPTH); idx = off[ADDR_W+1:2].
//   Write, en=1 && we!=0:
//     - In-window: on the accepting edge, each lane with we[i]=1 is updated; other lanes
//       are unchanged. wr_count increments.
//     - Out-of-window: array is unchanged, but wr_count still increments. addr_err pulses
//       RD_LAT cycles later; rdata_valid stays 0 for a write.
//   Read, en=1 && we==0:
//     - Captured on the accepting edge and carried through an RD_LAT-deep pipeline of
//       {valid, err, data}. rd_count increments.
//     - RD_LAT edges later: rdata_valid=1, data_sram_rdata = word, addr_err = !in_win.
//     - Out-of-window reads return 32'h0.
//     - With RD_LAT=1 and en held every cycle, back-to-back reads give one result per cycle.
//   Read data is sampled from the array at the accepting edge:
//     - A read and a write to the same word in the same cycle cannot occur (one request
//       per cycle).
//     - A read at cycle t followed by a write at t+1 to the same word returns the PRE-write
//       value, even when RD_LAT>1 (no retroactive update of in-flight reads).
//   en=0: no array change, no counter change; pipeline still advances; rdata holds.
//   Multiple requests may be in flight. Each completes in order, exactly RD_LAT cycles
//     after its acceptance.
//   Reset mid-operation: in-flight reads are discarded (no rdata_valid after release);
//     writes already committed remain in the array.
//   X on addr/we while en=0 has no effect on any state.
// TESTING
//   1 reset, RD_LAT=1: write 0x1234_5678 @0x10 we=4'hF, then read @0x10
//     -> rdata=0x12345678, rdata_valid pulses 1 cycle after the read edge.
//   2 byte lanes: preload 0xAABBCCDD @0x20, write we=4'b0101 wdata=0x11223344, read
//     -> 0xAA22CC44.
//   3 RD_LAT=3, reads @0x0,0x4,0x8 on consecutive cycles -> three valid pulses on
//     consecutive cycles starting 3 cycles after the first read, in address order.
//   4 read @0x40 at t, write 0xFFFF_FFFF @0x40 at t+1 (RD_LAT=2) -> read returns old value;
//     a later read returns 0xFFFFFFFF.
//   5 read @BASE+4*DEPTH -> rdata=0, rdata_valid=1, addr_err=1 together; write there leaves
//     all array words unchanged, addr_err pulses, wr_count+1.
//   6 assert resetn=0 with 2 reads in flight (RD_LAT=3) -> outputs 0 immediately; after
//     release, no rdata_valid; counters 0; earlier written data still readable.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-memory responder: byte-enabled writes, reads returned RD_LAT cycles after acceptance with valid/err strobes.
// Accepts a request on every edge with en=1; never stalls, so there is no backpressure path.
module data_sram_responder #(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned RD_LAT = 1,
   parameter logic [31:0] BASE   = 32'h0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        rdata_valid,
   output logic        addr_err,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic [31:0]       mem [DEPTH];
   logic [31:0]       off;
   logic              in_win;
   logic [ADDR_W-1:0] idx;
   logic              req_rd;
   logic              req_wr;
   logic [31:0]       rd_word;

   logic [RD_LAT-1:0] p_vld;
   logic [RD_LAT-1:0] p_err;
   logic [31:0]       p_dat [RD_LAT];
   logic [RD_LAT:0]   vld_chain;
   logic [RD_LAT:0]   err_chain;
   logic [31:0]       dat_chain [RD_LAT+1];

   // Window test on the wrapped offset; DEPTH is a power of two so the upper bits must all be zero.
   assign off     = data_sram_addr - BASE;
   assign in_win  = (off >> (ADDR_W + 2)) == 32'd0;
   assign idx     = off[ADDR_W+1:2];
   assign req_rd  = data_sram_en && (data_sram_we == 4'b0000);
   assign req_wr  = data_sram_en && (data_sram_we != 4'b0000);
   assign rd_word = in_win ? mem[idx] : 32'h0;

   // Element 0 of each chain is the request seen this cycle; element i+1 is pipeline stage i.
   assign vld_chain = {p_vld, req_rd};
   assign err_chain = {p_err, data_sram_en && !in_win};

   always_comb begin
      dat_chain[0] = rd_word;
      for (int i = 0; i < RD_LAT; i++) begin
         dat_chain[i+1] = p_dat[i];
      end
   end

   always_ff @(posedge clk) begin
      if (req_wr && in_win) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_we[i]) begin
               mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   // Data stages load only behind a valid read, so the last stage holds the previous result.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         p_vld    <= '0;
         p_err    <= '0;
         rd_count <= '0;
         wr_count <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            p_dat[i] <= '0;
         end
      end else begin
         p_vld <= vld_chain[RD_LAT-1:0];
         p_err <= err_chain[RD_LAT-1:0];
         for (int i = 0; i < RD_LAT; i++) begin
            if (vld_chain[i]) begin
               p_dat[i] <= dat_chain[i];
            end
         end
         if (req_rd) begin
            rd_count <= rd_count + 32'd1;
         end
         if (req_wr) begin
            wr_count <= wr_count + 32'd1;
         end
      end
   end

   assign data_sram_rdata = p_dat[RD_LAT-1];
   assign rdata_valid     = p_vld[RD_LAT-1];
   assign addr_err        = p_err[RD_LAT-1];

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (RD_LAT 1, 2, 3) share one request stream
// and are checked against a history-based reference model plus directed scenarios.
module tb_data_sram_responder;
   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0;
   localparam int          NDUT  = 3;

   logic        clk = 1'b0;
   logic        resetn;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic [31:0] rdata [NDUT];
   logic        vld   [NDUT];
   logic        err   [NDUT];
   logic [31:0] rdc   [NDUT];
   logic [31:0] wrc   [NDUT];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   data_sram_responder #(.DEPTH(DEPTH), .RD_LAT(1), .BASE(BASE)) u_lat1 (
      .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
      .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata[0]),
      .rdata_valid(vld[0]), .addr_err(err[0]), .rd_count(rdc[0]), .wr_count(wrc[0]));

   data_sram_responder #(.DEPTH(DEPTH), .RD_LAT(2), .BASE(BASE)) u_lat2 (
      .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
      .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata[1]),
      .rdata_valid(vld[1]), .addr_err(err[1]), .rd_count(rdc[1]), .wr_count(wrc[1]));

   data_sram_responder #(.DEPTH(DEPTH), .RD_LAT(3), .BASE(BASE)) u_lat3 (
      .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_we(we),
      .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata[2]),
      .rdata_valid(vld[2]), .addr_err(err[2]), .rd_count(rdc[2]), .wr_count(wrc[2]));

   // Reference model: one outcome record per clock edge; an instance of latency L shows the record L-1 edges back.
   typedef struct {
      bit          vld;
      bit          err;
      logic [31:0] dat;
   } rec_t;

   rec_t        hist [$];
   logic [31:0] mdl_mem [int unsigned];
   logic [31:0] exp_dat [NDUT];
   bit          exp_vld [NDUT];
   bit          exp_err [NDUT];
   logic [31:0] exp_rdc;
   logic [31:0] exp_wrc;

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < NDUT; k++) begin
         exp_dat[k] = 32'h0;
         exp_vld[k] = 1'b0;
         exp_err[k] = 1'b0;
      end
      exp_rdc = 32'h0;
      exp_wrc = 32'h0;
   endtask

   task automatic tick();
      rec_t        r;
      rec_t        rr;
      bit          live;
      bit          is_wr;
      bit          win;
      logic [31:0] off;
      logic [31:0] nw;
      int unsigned w;
      r.vld = 1'b0; r.err = 1'b0; r.dat = 32'h0;
      is_wr = 1'b0; win = 1'b0; w = 0; nw = 32'h0;
      live = (resetn === 1'b1) && (en === 1'b1);
      if (live) begin
         off   = addr - BASE;
         win   = off < 4 * DEPTH;
         w     = off / 4;
         is_wr = (we != 4'b0000);
         r.err = !win;
         if (!is_wr) begin
            r.vld = 1'b1;
            r.dat = (win && mdl_mem.exists(w)) ? mdl_mem[w] : 32'h0;
         end else if (win) begin
            nw = mdl_mem.exists(w) ? mdl_mem[w] : 32'h0;
            for (int i = 0; i < 4; i++) begin
               if (we[i]) nw[8*i +: 8] = wdata[8*i +: 8];
            end
         end
      end
      @(posedge clk);
      #1;
      if (resetn !== 1'b1) begin
         model_reset();
         return;
      end
      if (live) begin
         if (is_wr) begin
            exp_wrc = exp_wrc + 32'd1;
            if (win) mdl_mem[w] = nw;
         end else begin
            exp_rdc = exp_rdc + 32'd1;
         end
      end
      hist.push_back(r);
      if (hist.size() > 4) void'(hist.pop_front());
      for (int k = 0; k < NDUT; k++) begin
         if (hist.size() >= k + 1) begin
            rr = hist[hist.size() - 1 - k];
            exp_vld[k] = rr.vld;
            exp_err[k] = rr.err;
            if (rr.vld) exp_dat[k] = rr.dat;
         end else begin
            exp_vld[k] = 1'b0;
            exp_err[k] = 1'b0;
         end
      end
   endtask

   task automatic req(input logic [3:0] w_e, input logic [31:0] a, input logic [31:0] d);
      en = 1'b1; we = w_e; addr = a; wdata = d;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         en = 1'b0; we = 'x; addr = 'x; wdata = 'x;
         tick();
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
      model_reset();
      idle(3);
      for (int k = 0; k < NDUT; k++) begin
         n_tests++; if (rdata[k] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", k, rdata[k]); end
         n_tests++; if (vld[k] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 0", k, vld[k]); end
         n_tests++; if (err[k] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b expected 0", k, err[k]); end
         n_tests++; if (rdc[k] !== 32'h0) begin n_fail++; $display("FAIL reset_rd_count[%0d]: got %0d expected 0", k, rdc[k]); end
         n_tests++; if (wrc[k] !== 32'h0) begin n_fail++; $display("FAIL reset_wr_count[%0d]: got %0d expected 0", k, wrc[k]); end
      end
      resetn = 1'b1;
      idle(1);
   endtask

   task automatic test_write_read();
      req(4'hF, 32'h10, 32'h1234_5678);
      n_tests++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL wr_no_valid: got %b expected 0", vld[0]); end
      req(4'h0, 32'h10, 32'h0);
      n_tests++; if (vld[0] !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b expected 1", vld[0]); end
      n_tests++; if (rdata[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_data: got %h expected 12345678", rdata[0]); end
      idle(1);
      n_tests++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_end: got %b expected 0", vld[0]); end
      n_tests++; if (rdata[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_hold: got %h expected 12345678", rdata[0]); end
      n_tests++; if (rdc[0] !== 32'd1 || wrc[0] !== 32'd1) begin n_fail++; $display("FAIL counts: got rd %0d wr %0d expected 1 1", rdc[0], wrc[0]); end
   endtask

   task automatic test_byte_lanes();
      req(4'hF, 32'h20, 32'hAABB_CCDD);
      req(4'b0101, 32'h20, 32'h1122_3344);
      req(4'h0, 32'h22, 32'h0);
      n_tests++; if (rdata[0] !== 32'hAA22_CC44 || vld[0] !== 1'b1) begin n_fail++; $display("FAIL byte_lanes: got %h/%b expected aa22cc44/1", rdata[0], vld[0]); end
   endtask

   task automatic test_lat3_stream();
      logic [31:0] vals [3];
      bit          want;
      vals[0] = 32'hA0A0_0000; vals[1] = 32'hB1B1_0004; vals[2] = 32'hC2C2_0008;
      for (int i = 0; i < 3; i++) req(4'hF, 32'(4 * i), vals[i]);
      for (int i = 0; i < 6; i++) begin
         if (i < 3) req(4'h0, 32'(4 * i), 32'h0);
         else idle(1);
         want = (i >= 2 && i <= 4);
         n_tests++; if (vld[2] !== want) begin n_fail++; $display("FAIL lat3_valid[%0d]: got %b expected %b", i, vld[2], want); end
         if (want) begin
            n_tests++; if (rdata[2] !== vals[i-2]) begin n_fail++; $display("FAIL lat3_data[%0d]: got %h expected %h", i, rdata[2], vals[i-2]); end
         end
      end
   endtask

   task automatic test_read_then_write();
      req(4'hF, 32'h40, 32'h0BAD_F00D);
      idle(2);
      req(4'h0, 32'h40, 32'h0);
      req(4'hF, 32'h40, 32'hFFFF_FFFF);
      n_tests++; if (vld[1] !== 1'b1 || rdata[1] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL raw_lat2: got %h/%b expected 0badf00d/1", rdata[1], vld[1]); end
      idle(1);
      n_tests++; if (vld[2] !== 1'b1 || rdata[2] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL raw_lat3: got %h/%b expected 0badf00d/1", rdata[2], vld[2]); end
      req(4'h0, 32'h40, 32'h0);
      idle(1);
      n_tests++; if (vld[1] !== 1'b1 || rdata[1] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL raw_new: got %h/%b expected ffffffff/1", rdata[1], vld[1]); end
   endtask

   task automatic test_out_of_window();
      logic [31:0] wr_before;
      req(4'h0, BASE + 4 * DEPTH, 32'h0);
      n_tests++; if (rdata[0] !== 32'h0 || vld[0] !== 1'b1 || err[0] !== 1'b1) begin n_fail++; $display("FAIL oow_read: got %h/%b/%b expected 0/1/1", rdata[0], vld[0], err[0]); end
      wr_before = exp_wrc;
      req(4'hF, BASE + 4 * DEPTH, 32'hDEAD_BEEF);
      n_tests++; if (err[0] !== 1'b1 || vld[0] !== 1'b0) begin n_fail++; $display("FAIL oow_write_flags: got err %b valid %b expected 1 0", err[0], vld[0]); end
      n_tests++; if (wrc[0] !== wr_before + 32'd1) begin n_fail++; $display("FAIL oow_wr_count: got %0d expected %0d", wrc[0], wr_before + 32'd1); end
      req(4'h0, 32'h0, 32'h0);
      n_tests++; if (rdata[0] !== 32'hA0A0_0000 || err[0] !== 1'b0) begin n_fail++; $display("FAIL oow_alias_word0: got %h/%b expected a0a00000/0", rdata[0], err[0]); end
      req(4'h0, 32'h10, 32'h0);
      n_tests++; if (rdata[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL oow_word10: got %h expected 12345678", rdata[0]); end
   endtask

   task automatic test_reset_midflight();
      idle(3);
      req(4'h0, 32'h0, 32'h0);
      req(4'h0, 32'h4, 32'h0);
      en = 1'b0; we = 4'h0;
      resetn = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < NDUT; k++) begin
         n_tests++; if (rdata[k] !== 32'h0 || vld[k] !== 1'b0 || err[k] !== 1'b0) begin n_fail++; $display("FAIL async_rst_out[%0d]: got %h/%b/%b expected 0/0/0", k, rdata[k], vld[k], err[k]); end
         n_tests++; if (rdc[k] !== 32'h0 || wrc[k] !== 32'h0) begin n_fail++; $display("FAIL async_rst_cnt[%0d]: got %0d %0d expected 0 0", k, rdc[k], wrc[k]); end
      end
      idle(2);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         idle(1);
         n_tests++; if (vld[2] !== 1'b0 || vld[1] !== 1'b0) begin n_fail++; $display("FAIL flushed_valid[%0d]: got %b %b expected 0 0", i, vld[1], vld[2]); end
      end
      req(4'h0, 32'h10, 32'h0);
      n_tests++; if (rdata[0] !== 32'h1234_5678 || vld[0] !== 1'b1) begin n_fail++; $display("FAIL post_rst_read: got %h/%b expected 12345678/1", rdata[0], vld[0]); end
      n_tests++; if (rdc[0] !== 32'd1 || wrc[0] !== 32'd0) begin n_fail++; $display("FAIL post_rst_cnt: got %0d %0d expected 1 0", rdc[0], wrc[0]); end
   endtask

   task automatic test_random();
      int unsigned sel;
      logic [31:0] a;
      for (int i = 0; i < 16; i++) req(4'hF, 32'h100 + 32'(4 * i), $urandom);
      for (int c = 0; c < 400; c++) begin
         sel = $urandom_range(0, 9);
         a   = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         if (sel == 6 || sel == 9) begin
            a = ($urandom_range(0, 1) == 0) ? BASE + 4 * DEPTH + 32'(4 * $urandom_range(0, 500))
                                            : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         end
         case (sel)
            0, 1:       idle(1);
            2, 3, 4, 5, 6: req(4'h0, a, $urandom);
            default:    req(4'($urandom_range(1, 15)), a, $urandom);
         endcase
         for (int k = 0; k < NDUT; k++) begin
            n_tests++; if (vld[k] !== exp_vld[k]) begin n_fail++; $display("FAIL rnd_valid[%0d] c%0d: got %b expected %b", k, c, vld[k], exp_vld[k]); end
            n_tests++; if (err[k] !== exp_err[k]) begin n_fail++; $display("FAIL rnd_err[%0d] c%0d: got %b expected %b", k, c, err[k], exp_err[k]); end
            n_tests++; if (rdata[k] !== exp_dat[k]) begin n_fail++; $display("FAIL rnd_rdata[%0d] c%0d: got %h expected %h", k, c, rdata[k], exp_dat[k]); end
            n_tests++; if (rdc[k] !== exp_rdc || wrc[k] !== exp_wrc) begin n_fail++; $display("FAIL rnd_counts[%0d] c%0d: got %0d %0d expected %0d %0d", k, c, rdc[k], wrc[k], exp_rdc, exp_wrc); end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_lat3_stream();
      test_read_then_write();
      test_out_of_window();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
